// File: rtl/operand_bypass_unit.sv
// -----------------------------------------------------------------------------
// operand_bypass_unit
//
// Consumer side of the forwarding network. Every cycle the six register-fetch
// source addresses (ra/rb/rc of the even and odd pipes) are compared against
// every forwarding-tap packet. The youngest matching tap value is registered
// toward execute, or the register-file value if no tap matches. A per-register
// countdown scoreboard stalls issue while a source's producer has not yet
// reached a tap.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   issue_valid_even/odd        instruction present in the fetch slot
//   ra/rb/rc_addr_even/odd      source register addresses
//   ra/rb/rc_rd_even/odd        register-file read data for each source
//   dest_we/addr/lat_even/odd   destination write enable, register, latency
//   fw_even_taps/fw_odd_taps    packed tap packets {unit_id, we, addr, value},
//                               tap 0 (youngest) in the MSBs
//   stall                       combinational; bundle not accepted this cycle
//   op_valid_even/odd           registered operands valid
//   fw_ra/rb/rc_even/odd_out    registered operands
//   fw_hit                      {ra_e,rb_e,rc_e,ra_o,rb_o,rc_o}; 1 = from a tap
// -----------------------------------------------------------------------------
module operand_bypass_unit #(
  parameter int UNIT_ID_SIZE   = 4,
  parameter int REG_ADDR_WIDTH = 7,
  parameter int QUADWORD       = 128,
  parameter int NUM_EVEN_TAPS  = 6,
  parameter int NUM_ODD_TAPS   = 5,
  parameter int LAT_WIDTH      = 4,
  localparam int PKT_W = UNIT_ID_SIZE + 1 + REG_ADDR_WIDTH + QUADWORD
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           issue_valid_even,
  input  logic                           issue_valid_odd,
  input  logic [REG_ADDR_WIDTH-1:0]      ra_addr_even,
  input  logic [REG_ADDR_WIDTH-1:0]      rb_addr_even,
  input  logic [REG_ADDR_WIDTH-1:0]      rc_addr_even,
  input  logic [REG_ADDR_WIDTH-1:0]      ra_addr_odd,
  input  logic [REG_ADDR_WIDTH-1:0]      rb_addr_odd,
  input  logic [REG_ADDR_WIDTH-1:0]      rc_addr_odd,
  input  logic [QUADWORD-1:0]            ra_rd_even,
  input  logic [QUADWORD-1:0]            rb_rd_even,
  input  logic [QUADWORD-1:0]            rc_rd_even,
  input  logic [QUADWORD-1:0]            ra_rd_odd,
  input  logic [QUADWORD-1:0]            rb_rd_odd,
  input  logic [QUADWORD-1:0]            rc_rd_odd,
  input  logic                           dest_we_even,
  input  logic                           dest_we_odd,
  input  logic [REG_ADDR_WIDTH-1:0]      dest_addr_even,
  input  logic [REG_ADDR_WIDTH-1:0]      dest_addr_odd,
  input  logic [LAT_WIDTH-1:0]           dest_lat_even,
  input  logic [LAT_WIDTH-1:0]           dest_lat_odd,
  input  logic [NUM_EVEN_TAPS*PKT_W-1:0] fw_even_taps,
  input  logic [NUM_ODD_TAPS*PKT_W-1:0]  fw_odd_taps,
  output logic                           stall,
  output logic                           op_valid_even,
  output logic                           op_valid_odd,
  output logic [QUADWORD-1:0]            fw_ra_even_out,
  output logic [QUADWORD-1:0]            fw_rb_even_out,
  output logic [QUADWORD-1:0]            fw_rc_even_out,
  output logic [QUADWORD-1:0]            fw_ra_odd_out,
  output logic [QUADWORD-1:0]            fw_rb_odd_out,
  output logic [QUADWORD-1:0]            fw_rc_odd_out,
  output logic [5:0]                     fw_hit
);

  localparam int NUM_REGS = 1 << REG_ADDR_WIDTH;
  localparam int ADDR_LSB = QUADWORD;
  localparam int WE_BIT   = QUADWORD + REG_ADDR_WIDTH;

  // Source index order: 0..2 = ra/rb/rc even, 3..5 = ra/rb/rc odd.
  logic [REG_ADDR_WIDTH-1:0] src [6];
  logic [QUADWORD-1:0]       rf  [6];
  logic [QUADWORD:0]         sel [6];   // {hit, value}
  logic [5:0]                busy;
  logic                      accept;

  logic [LAT_WIDTH-1:0] pend_q [NUM_REGS];
  logic [LAT_WIDTH-1:0] pend_d [NUM_REGS];
  logic                 op_valid_even_q, op_valid_odd_q;
  logic [QUADWORD-1:0]  op_q [6];
  logic [5:0]           hit_q;

  assign src = '{ra_addr_even, rb_addr_even, rc_addr_even,
                 ra_addr_odd,  rb_addr_odd,  rc_addr_odd};
  assign rf  = '{ra_rd_even, rb_rd_even, rc_rd_even,
                 ra_rd_odd,  rb_rd_odd,  rc_rd_odd};

  // Youngest match wins. Ranks are ordered by stage number (even tap i sits at
  // stage i+3, odd tap j at stage j+4); on an equal stage the even tap gets the
  // lower rank, so even wins ties.
  function automatic logic [QUADWORD:0] select_operand(
    input logic [REG_ADDR_WIDTH-1:0]      src_addr,
    input logic [QUADWORD-1:0]            rf_data,
    input logic [NUM_EVEN_TAPS*PKT_W-1:0] even_taps,
    input logic [NUM_ODD_TAPS*PKT_W-1:0]  odd_taps
  );
    logic [PKT_W-1:0]  pkt;
    logic [QUADWORD:0] pick;
    int                best_rank;
    pick      = {1'b0, rf_data};
    best_rank = 2 * (NUM_EVEN_TAPS + NUM_ODD_TAPS) + 4;
    for (int i = 0; i < NUM_EVEN_TAPS; i++) begin
      pkt = even_taps[(NUM_EVEN_TAPS-1-i)*PKT_W +: PKT_W];
      if (pkt[WE_BIT] && (pkt[ADDR_LSB +: REG_ADDR_WIDTH] == src_addr) && (2*i < best_rank)) begin
        best_rank = 2*i;
        pick      = {1'b1, pkt[QUADWORD-1:0]};
      end
    end
    for (int j = 0; j < NUM_ODD_TAPS; j++) begin
      pkt = odd_taps[(NUM_ODD_TAPS-1-j)*PKT_W +: PKT_W];
      if (pkt[WE_BIT] && (pkt[ADDR_LSB +: REG_ADDR_WIDTH] == src_addr) && (2*j+3 < best_rank)) begin
        best_rank = 2*j + 3;
        pick      = {1'b1, pkt[QUADWORD-1:0]};
      end
    end
    return pick;
  endfunction

  always_comb begin
    for (int k = 0; k < 6; k++) begin
      sel[k] = select_operand(src[k], rf[k], fw_even_taps, fw_odd_taps);
      // A count of 1 means the producer lands on its tap this cycle, so the
      // value is already forwardable; only larger counts must wait.
      busy[k] = pend_q[src[k]] > LAT_WIDTH'(1);
    end
  end

  // Unit ids travel with the packets but play no part in operand selection.
  logic unused_unit_ids;
  always_comb begin
    unused_unit_ids = 1'b0;
    for (int i = 0; i < NUM_EVEN_TAPS; i++)
      unused_unit_ids = unused_unit_ids ^ (^fw_even_taps[(NUM_EVEN_TAPS-1-i)*PKT_W + PKT_W-1 -: UNIT_ID_SIZE]);
    for (int j = 0; j < NUM_ODD_TAPS; j++)
      unused_unit_ids = unused_unit_ids ^ (^fw_odd_taps[(NUM_ODD_TAPS-1-j)*PKT_W + PKT_W-1 -: UNIT_ID_SIZE]);
  end

  assign stall  = !reset && ((issue_valid_even && |busy[2:0]) ||
                             (issue_valid_odd  && |busy[5:3]));
  assign accept = !stall;

  // Scoreboard: age every entry, then let accepted producers raise their
  // destination. Applying the odd slot after the even one yields the max
  // when both target the same register.
  always_comb begin
    // NOTE: every always_comb target gets a value on every path (here the
    // decrement loop runs first), otherwise synthesis infers a latch.
    for (int r = 0; r < NUM_REGS; r++)
      pend_d[r] = (pend_q[r] != '0) ? pend_q[r] - LAT_WIDTH'(1) : '0;
    if (accept && issue_valid_even && dest_we_even && (dest_lat_even > pend_d[dest_addr_even]))
      pend_d[dest_addr_even] = dest_lat_even;
    if (accept && issue_valid_odd && dest_we_odd && (dest_lat_odd > pend_d[dest_addr_odd]))
      pend_d[dest_addr_odd] = dest_lat_odd;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs, independent of statement order.
    if (reset) begin
      // NOTE: the scoreboard array is reset explicitly; a stale nonzero count
      // after reset would stall issue on a producer that no longer exists.
      for (int r = 0; r < NUM_REGS; r++) pend_q[r] <= '0;
      for (int k = 0; k < 6; k++) op_q[k] <= '0;
      hit_q           <= '0;
      op_valid_even_q <= 1'b0;
      op_valid_odd_q  <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) pend_q[r] <= pend_d[r];
      op_valid_even_q <= accept && issue_valid_even;
      op_valid_odd_q  <= accept && issue_valid_odd;
      if (accept) begin
        for (int k = 0; k < 6; k++) begin
          op_q[k]    <= sel[k][QUADWORD-1:0];
          hit_q[5-k] <= sel[k][QUADWORD];
        end
      end
    end
  end

  assign op_valid_even  = op_valid_even_q;
  assign op_valid_odd   = op_valid_odd_q;
  assign fw_ra_even_out = op_q[0];
  assign fw_rb_even_out = op_q[1];
  assign fw_rc_even_out = op_q[2];
  assign fw_ra_odd_out  = op_q[3];
  assign fw_rb_odd_out  = op_q[4];
  assign fw_rc_odd_out  = op_q[5];
  assign fw_hit         = hit_q;

  // An odd source naming the even destination of the same bundle is not
  // forwarded or stalled; flag such bundles instead of silently mis-issuing.
  logic intra_dep;
  assign intra_dep = accept && issue_valid_even && dest_we_even && issue_valid_odd &&
                     ((ra_addr_odd == dest_addr_even) || (rb_addr_odd == dest_addr_even) ||
                      (rc_addr_odd == dest_addr_even));

  a_no_intra_bundle_dep: assert property (@(posedge clk) disable iff (reset) !intra_dep);

endmodule
